// File: rtl/srt_div_sequencer.sv
// srt_div_sequencer: round-robin operand arbiter and load/iterate/capture sequencer for the FP32 SRT radix-4 divider; SRT_DIV_SEQ_SPECIAL_EN short-circuits zero operands
module srt_div_sequencer #(
    parameter int NUM_ITER = 14,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    output logic              div_rst_n,
    input  logic [DATA_W-1:0] div_quotient,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_quotient,
    output logic              busy
);
    localparam int CW = $clog2(NUM_ITER + 1);
    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;
    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_last_id;
    logic              w_grant;
    logic              w_accept;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              w_special;
    logic [DATA_W-1:0] w_special_q;
    always_comb begin
        w_grant    = r_last_id ? !req0_valid : req1_valid;
        req0_ready = (r_state == IDLE) && req0_valid && !w_grant;
        req1_ready = (r_state == IDLE) && req1_valid && w_grant;
        w_accept   = req0_ready || req1_ready;
        w_a        = w_grant ? req1_a : req0_a;
        w_b        = w_grant ? req1_b : req0_b;
    end
`ifdef SRT_DIV_SEQ_SPECIAL_EN
    logic w_sign;
    logic w_a_zero;
    logic w_b_zero;
    always_comb begin
        w_sign      = w_a[DATA_W-1] ^ w_b[DATA_W-1];
        w_a_zero    = w_a[DATA_W-2:0] == '0;
        w_b_zero    = w_b[DATA_W-2:0] == '0;
        w_special   = w_a_zero || w_b_zero;
        w_special_q = w_b_zero ? {w_sign, 8'hFF, {(DATA_W-9){1'b0}}} : {w_sign, {(DATA_W-1){1'b0}}};
    end
`else
    always_comb begin
        w_special   = 1'b0;
        w_special_q = '0;
    end
`endif
    // The divider runs only while in ITER; every other state holds it in reset.
    assign div_rst_n = (r_state == ITER);
    assign rsp_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_id    <= 1'b1;
            rsp_id       <= 1'b0;
            rsp_quotient <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    div_dividend <= w_a;
                    div_divisor  <= w_b;
                    rsp_id       <= w_grant;
                    r_last_id    <= w_grant;
                    rsp_quotient <= w_special ? w_special_q : rsp_quotient;
                    r_state      <= w_special ? DONE : LOAD;
                end
                LOAD: begin
                    r_cnt   <= '0;
                    r_state <= ITER;
                end
                ITER: if (r_cnt == CW'(NUM_ITER)) begin
                    rsp_quotient <= div_quotient;
                    r_state      <= DONE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: if (rsp_ready) r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_srt_div_sequencer.sv
// tb_srt_div_sequencer: scoreboard bench for srt_div_sequencer with a behavioural divider whose quotient is valid only on its NUM_ITER-th edge
module tb_srt_div_sequencer;
    localparam int NUM_ITER = 14;
    localparam int LAT_FULL = NUM_ITER + 3;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [31:0] div_dividend, div_divisor, div_quotient, rsp_quotient;
    logic        div_rst_n, rsp_valid, rsp_id, busy;
    logic        rsp_ready = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_cnt = 0;
    logic        prev_v = 1'b0;
    logic        saw_rst_n = 1'b0;
    typedef struct {logic id; logic [31:0] q; int lat;} exp_t;
    exp_t sb[$];
    int   acc_q[$];
    int   acc_log[$];

    srt_div_sequencer #(.NUM_ITER(NUM_ITER), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_rst_n(div_rst_n),
        .div_quotient(div_quotient), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_quotient(rsp_quotient), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40C00000, 32'h40000000}: return 32'h40400000;
            {32'h3F800000, 32'h40800000}: return 32'h3E800000;
            {32'h41200000, 32'h40A00000}: return 32'h40000000;
            {32'h41000000, 32'h40000000}: return 32'h40800000;
            default:                      return 32'h7FC00000;
        endcase
    endfunction

    always @(posedge clk) m_cnt <= div_rst_n ? m_cnt + 1 : 0;
    assign div_quotient = (m_cnt == NUM_ITER) ? fdiv(div_dividend, div_divisor) : 32'hDEADBEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (div_rst_n) saw_rst_n = 1'b1;
        if (rst) acc_q.delete();
        else if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            acc_q.push_back(cyc);
            acc_log.push_back(cyc);
        end
    end

    // Monitor: latency at the rising edge of rsp_valid, payload at the response handshake.
    always @(negedge clk) begin
        if (rst) prev_v = 1'b0;
        else begin
            if (rsp_valid && !prev_v) begin
                if (sb.size() == 0 || acc_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
                else chk("latency", 32'(cyc - acc_q.pop_front()), 32'(sb[0].lat));
            end
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                chk("rsp_quotient", rsp_quotient, sb[0].q);
                void'(sb.pop_front());
            end
            prev_v = rsp_valid;
        end
    end

    task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input int lat);
        bit ok = 0;
        sb.push_back('{id: id, q: q, lat: lat});
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        if (!ok) chk("accept_timeout", 32'(ok), 32'(1));
        @(posedge clk) #1;
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk) #1;
            ok = (sb.size() == 0) && !busy;
        end
        if (!ok) chk("done_timeout", 32'(ok), 32'(1));
    endtask

    task automatic wait_req(input logic id);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        if (!ok) chk("grant_timeout", 32'(ok), 32'(1));
        @(posedge clk) #1;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk) #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_quotient", rsp_quotient, 0);
        chk("rst_dividend", div_dividend, 0);
        chk("rst_divisor", div_divisor, 0);
        chk("rst_div_rst_n", 32'(div_rst_n), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 0;
    endtask

    initial begin
        bit ok;
        do_reset();
        send(0, 32'h40C00000, 32'h40000000, 32'h40400000, LAT_FULL);
        wait_done();
        send(1, 32'h3F800000, 32'h40800000, 32'h3E800000, LAT_FULL);
        wait_done();
        // Both requesters saturate the block; arbitration must alternate starting with 0.
        do_reset();
        acc_log.delete();
        sb.push_back('{id: 0, q: 32'h40400000, lat: LAT_FULL});
        sb.push_back('{id: 1, q: 32'h3E800000, lat: LAT_FULL});
        sb.push_back('{id: 0, q: 32'h40000000, lat: LAT_FULL});
        sb.push_back('{id: 1, q: 32'h40800000, lat: LAT_FULL});
        fork
            begin
                req0_valid = 1; req0_a = 32'h40C00000; req0_b = 32'h40000000;
                wait_req(0);
                req0_a = 32'h41200000; req0_b = 32'h40A00000;
                wait_req(0);
                req0_valid = 0;
            end
            begin
                req1_valid = 1; req1_a = 32'h3F800000; req1_b = 32'h40800000;
                wait_req(1);
                req1_a = 32'h41000000; req1_b = 32'h40000000;
                wait_req(1);
                req1_valid = 0;
            end
        join
        wait_done();
        chk("accepts", 32'(acc_log.size()), 4);
        for (int i = 1; i < acc_log.size(); i++) chk("throughput", 32'(acc_log[i] - acc_log[i-1]), 32'(NUM_ITER + 4));
        // Backpressure: DONE holds and no request is accepted.
        rsp_ready = 0;
        send(0, 32'h40C00000, 32'h40000000, 32'h40400000, LAT_FULL);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = rsp_valid;
        end
        if (!ok) chk("rsp_timeout", 32'(ok), 1);
        @(posedge clk) #1;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_quotient", rsp_quotient, 32'h40400000);
            chk("bp_id", 32'(rsp_id), 0);
            chk("bp_ready", {30'b0, req0_ready, req1_ready}, 0);
            chk("bp_busy", 32'(busy), 1);
        end
        @(posedge clk) #1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        @(posedge clk) #1;
        chk("release_idle", {30'b0, busy, rsp_valid}, 0);
        // Abort mid-ITER once cnt has reached 5.
        send(0, 32'h40C00000, 32'h40000000, 32'h40400000, LAT_FULL);
        repeat (6) @(posedge clk);
        #1;
        chk("iter_div_rst_n", 32'(div_rst_n), 1);
        sb.delete();
        do_reset();
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_rsp", {30'b0, busy, rsp_valid}, 0);
        send(1, 32'h3F800000, 32'h40800000, 32'h3E800000, LAT_FULL);
        wait_done();
        // Zero divisor: short-circuited when the special-operand path is built in.
        @(posedge clk) #1;
        saw_rst_n = 0;
`ifdef SRT_DIV_SEQ_SPECIAL_EN
        send(0, 32'hBF800000, 32'h00000000, 32'hFF800000, 1);
        wait_done();
        chk("special_div_rst_n", 32'(saw_rst_n), 0);
`else
        send(0, 32'hBF800000, 32'h00000000, 32'h7FC00000, LAT_FULL);
        wait_done();
        chk("zero_div_rst_n", 32'(saw_rst_n), 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
